// File: rtl/rcmd_pkg.sv
// Shared types and constants for the remote command link arbiter.
package rcmd_pkg;

    localparam int unsigned CMD_W        = 16;
    localparam logic [7:0]  ACK_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_SENT,
        ST_WAIT_RESP,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             any,
    output logic [ID_W-1:0]  gnt_id
);

    int unsigned     idx;
    logic [ID_W-1:0] idx_w;
    logic            found;

    always_comb begin
        any    = |req;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx   = (32'(rr_ptr) + k) % N_REQ;
            idx_w = ID_W'(idx);
            if (!found && req[idx_w]) begin
                gnt_id = idx_w;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/remote_cmd_arbiter.sv
// Shares one UART command link between N_REQ sources: round-robin grant,
// one command in flight, ACK/NACK/timeout handling with bounded retries.
module remote_cmd_arbiter
    import rcmd_pkg::*;
#(
    parameter  int unsigned N_REQ     = 4,
    parameter  int unsigned TIMEOUT   = 1000000,
    parameter  int unsigned MAX_RETRY = 2,
    parameter  logic [7:0]  ACK_BYTE  = ACK_BYTE_DEF,
    localparam int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [CMD_W*N_REQ-1:0] req_cmd,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   done_ok,
    output logic                   send_cmd,
    output logic [CMD_W-1:0]       cmd,
    input  logic                   cmd_sent,
    input  logic [7:0]             resp,
    input  logic                   resp_rdy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               ok_q, ok_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               done_ok_q, done_ok_d;
    logic               send_cmd_q, send_cmd_d;

    logic               any;
    logic [ID_W-1:0]    gnt_id;
    logic               tmo_hit;
    logic               attempt_fail;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (any),
        .gnt_id (gnt_id)
    );

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        cmd_d        = cmd_q;
        ok_d         = ok_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    id_d    = gnt_id;
                    cmd_d   = req_cmd[32'(gnt_id)*CMD_W +: CMD_W];
                    retry_d = '0;
                    ok_d    = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
                // cmd_sent may still show the previous command while send_cmd is high.
                if (cmd_sent && !send_cmd_q) state_d = ST_WAIT_RESP;
                else if (tmo_hit)            attempt_fail = 1'b1;
            end
            ST_WAIT_RESP: begin
                if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
                if (resp_rdy && (resp == ACK_BYTE)) begin
                    ok_d    = 1'b1;
                    state_d = ST_FINISH;
                end else if (resp_rdy || tmo_hit) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_FINISH: begin
                rr_ptr_d = (32'(id_q) == N_REQ - 1) ? '0 : id_q + ID_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (attempt_fail) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = ST_ISSUE;
            end else begin
                ok_d    = 1'b0;
                state_d = ST_FINISH;
            end
        end

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FINISH);
        send_cmd_d = (state_q == ST_ISSUE);
        done_id_d  = (state_d == ST_FINISH) ? id_q : done_id_q;
        done_ok_d  = (state_d == ST_FINISH) ? ok_d : done_ok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            rr_ptr_q   <= '0;
            cmd_q      <= '0;
            ok_q       <= 1'b0;
            retry_q    <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            done_ok_q  <= 1'b0;
            send_cmd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            rr_ptr_q   <= rr_ptr_d;
            cmd_q      <= cmd_d;
            ok_q       <= ok_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            done_ok_q  <= done_ok_d;
            send_cmd_q <= send_cmd_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign done_ok  = done_ok_q;
    assign send_cmd = send_cmd_q;
    assign cmd      = cmd_q;

endmodule
